uart_rx_ctrl: RTL

//   UART receive control for the APB serial peripheral. Synchronises the raw RX line.

---
 rtl/uart_rx_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive control for the APB serial peripheral.
// Synchronises the RX line and qualifies the start bit at mid-bit.
// Strobes an external 9-bit shift register once per bit.
// Loads good frames into the RX buffer and flags framing/overrun errors.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic [7:0] packet_data,
  input  logic       stop_bit,
  input  logic       data_read,
  output logic       shift_strobe,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RECV  = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             sync_meta;
  logic             sync_rx;
  logic             sync_prev;
  logic             fall_edge;

  // Two-flop synchroniser plus a history flop; all reset to the idle-high line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync_rx   <= sync_meta;
      sync_prev <= sync_rx;
    end
  end

  assign fall_edge = sync_prev & ~sync_rx;
  assign busy      = (state != IDLE);

  // Frame sequencing; the strobe is registered one cycle early so it lands on clk_cnt == CLKS_PER_BIT-1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_strobe <= 1'b0;
    end else begin
      shift_strobe <= (state == RECV) && (clk_cnt == CNT_PRE);
      case (state)
        IDLE: begin
          if (fall_edge) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!sync_rx) begin
              state   <= RECV;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RECV: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state <= CHECK;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Receive buffer and status flags; a good-frame load takes priority over a same-cycle read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= 8'h00;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if ((state == CHECK) && stop_bit) begin
      rx_data       <= packet_data;
      data_ready    <= 1'b1;
      framing_error <= 1'b0;
      overrun_error <= data_ready & ~data_read;
    end else if (state == CHECK) begin
      framing_error <= 1'b1;
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end else if (data_read) begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule
